axi_master_bridge: RTL and testbench
====================================

// Module: axi_master_bridge
// PURPOSE
//  Downstream of the cache/AXI arbitration interface. Converts its simplified
//  bus (level ren/wen, per-beat rvalid, single bvalid) into AXI4 master channels.
//  Provides one independent read engine (INCR burst, 1..16 beats) and one write engine (single beat).
//  Output ports connect directly to the SoC AXI crossbar.
// PARAMETERS
//  ID_W      4     AXI ID width
//  RD_ID     0     constant m_axi_arid;  WR_ID  1  constant m_axi_awid
// PORTS
//  clk                    in   1   clock
//  rst                    in   1   synchronous reset, active-high
//  cache_ce_i             in   1   chip enable; while 0, new requests are ignored
//  cache_ren_i            in   1   read request, held high until the last beat
//  cache_rready_i         in   1   upstream ready for beats -> m_axi_rready
//  cache_raddr_i          in   32  read address, word aligned
//  cache_rlen_i           in   4   beats-1 (0=word, 7=I-line)
//  cache_rdata_o          out  32  beat data (m_axi_rdata passthrough)
//  cache_rvalid_o         out  1   beat valid = m_axi_rvalid & m_axi_rready in R_DATA
//  cache_wen_i            in   1   write request, held high until cache_bvalid_o
//  cache_waddr_i          in   32  write address, word aligned
//  cache_wdata_i          in   32  write data, valid when cache_wvalid_i
//  cache_wvalid_i         in   1   write data valid
//  cache_bvalid_o         out  1   write done = m_axi_bvalid & m_axi_bready in W_RESP
//  bus_err_o              out  1   sticky: set on any rresp/bresp != 0; cleared only by rst
//  m_axi_arid / awid      out  ID_W  RD_ID / WR_ID
//  m_axi_araddr / awaddr  out  32  latched request address
//  m_axi_arlen            out  8   {4'b0, latched cache_rlen_i};  m_axi_awlen out 8 = 0
//  m_axi_arsize / awsize  out  3   3'b010;  m_axi_arburst / awburst out 2 = 2'b01 (INCR)
//  m_axi_{ar,aw}lock/cache/prot out 2/4/3  all zero
//  m_axi_arvalid out 1 / m_axi_arready in 1    AR handshake
//  m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rlast in 1, m_axi_rvalid in 1, m_axi_rready out 1
//  m_axi_awvalid out 1 / m_axi_awready in 1    AW handshake
//  m_axi_wdata out 32, m_axi_wstrb out 4 (4'hF), m_axi_wlast out 1 (=1), m_axi_wvalid out 1, m_axi_wready in 1
//  m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1
// BEHAVIOUR
//  Reset: both FSMs return to IDLE; all valid/ready outputs 0; address/len latches 0;
//   bus_err_o 0. Reset mid-burst aborts the burst immediately (system-wide reset).
//  Read FSM R_IDLE -> R_AR -> R_DATA -> R_IDLE:
//   R_IDLE: if cache_ce_i & cache_ren_i, latch raddr/rlen, go R_AR (arvalid=1 next cycle).
//   R_AR: arvalid held with address stable until arready; then go R_DATA.
//   R_DATA: rready = cache_rready_i; each handshake asserts cache_rvalid_o the same cycle
//    (combinational, 0-cycle data latency); the beat with rlast returns to R_IDLE.
//   Beats are counted internally; rlast received before rlen+1 beats, or missing
//    at beat rlen+1 -> set bus_err_o; FSM still exits on rlast.
//   Accepted-request minimum latency: ren high at cycle 0 -> arvalid at cycle 1.
//   In the cycle after return to R_IDLE, ren high is treated as a new request.
//  Write FSM W_IDLE -> W_REQ -> W_RESP -> W_IDLE:
//   W_IDLE: if cache_ce_i & cache_wen_i, latch waddr, go W_REQ with awvalid=1.
//   W_REQ: awvalid until awready (aw_done flag); wvalid = cache_wvalid_i & !w_done,
//    wdata latched on first cycle cache_wvalid_i=1 and driven from latch;
//    AW and W complete in either order or in the same cycle; W may precede AW.
//    When both are done, go W_RESP.
//   W_RESP: bready=1; on bvalid, pulse cache_bvalid_o for that cycle only, go W_IDLE.
//  Read and write engines are fully independent; simultaneous operation is legal.
//  bresp/rresp SLVERR/DECERR: data is still forwarded and bus_err_o is set.
//  cache_ce_i=0 only blocks leaving IDLE; transactions in flight complete normally.
// TESTING
//  1. rlen=0, raddr=0x1FC0_0004, arready at cycle 2, one rvalid+rlast with 0xDEADBEEF
//     -> arlen=0, araddr=0x1FC0_0004, exactly one cache_rvalid_o carrying 0xDEADBEEF.
//  2. rlen=7, raddr=0x0000_0100, rvalid gaps of 0-3 random cycles -> arlen=7,
//     8 cache_rvalid_o pulses in order, FSM in R_IDLE the cycle after rlast.
//  3. Write 0x8000_0010/0x12345678: wready before awready, then same-cycle case
//     -> one AW and one W, wstrb=F, wlast=1, single cache_bvalid_o pulse.
//  4. Concurrent 8-beat read and write, random ready/valid stalls -> both complete;
//     beat data order preserved; no extra handshakes.
//  5. bresp=2'b10 on a write, later read OK -> bus_err_o rises with bvalid and stays 1.
//  6. rst asserted during beat 4 of 8 -> next cycle all valids/readies 0, both FSMs IDLE,
//     a new rlen=0 read completes normally.

Source files
------------

// File: rtl/axi_master_bridge_if.sv
// AXI4 master-side channel bundle between the bridge and the SoC crossbar.
// Ports (modport master = bridge view, modport slave = crossbar view):
//   AR/R  : arid araddr arlen arsize arburst arlock arcache arprot arvalid arready,
//           rdata rresp rlast rvalid rready
//   AW/W/B: awid awaddr awlen awsize awburst awlock awcache awprot awvalid awready,
//           wdata wstrb wlast wvalid wready, bresp bvalid bready
interface axi_master_bridge_if #(
    parameter int unsigned ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_master_bridge.sv
// Converts the cache-side level request bus into AXI4 master channels.
// One INCR read engine (1..16 beats) and one single-beat write engine, independent.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cache_ce_i               gates acceptance of new requests only
//   cache_ren_i/raddr/rlen   read request (held until last beat), cache_rready_i beat ready
//   cache_rdata_o/rvalid_o   per-beat data, combinational from the R channel
//   cache_wen_i/waddr/wdata  write request (held until cache_bvalid_o), cache_wvalid_i data valid
//   cache_bvalid_o           one-cycle write completion pulse
//   bus_err_o                sticky error (bad resp or burst length mismatch)
//   m_axi                    AXI4 master channels
module axi_master_bridge #(
    parameter int unsigned ID_W  = 4,
    parameter int unsigned RD_ID = 0,
    parameter int unsigned WR_ID = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_ce_i,
    input  logic        cache_ren_i,
    input  logic        cache_rready_i,
    input  logic [31:0] cache_raddr_i,
    input  logic [3:0]  cache_rlen_i,
    output logic [31:0] cache_rdata_o,
    output logic        cache_rvalid_o,
    input  logic        cache_wen_i,
    input  logic [31:0] cache_waddr_i,
    input  logic [31:0] cache_wdata_i,
    input  logic        cache_wvalid_i,
    output logic        cache_bvalid_o,
    output logic        bus_err_o,
    axi_master_bridge_if.master m_axi
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;

    rd_state_t         r_state, r_state_nxt;
    logic [ADDR_W-1:0] raddr_q, raddr_nxt;
    logic [LEN_W-1:0]  rlen_q, rlen_nxt;
    logic [LEN_W-1:0]  beat_q, beat_nxt;
    logic              r_hs_c;
    logic              r_err_c;

    wr_state_t         w_state, w_state_nxt;
    logic [ADDR_W-1:0] waddr_q, waddr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              wdata_vld_q, wdata_vld_nxt;
    logic              aw_done_q, aw_done_nxt;
    logic              w_done_q, w_done_nxt;
    logic              aw_hs_c, w_hs_c, b_hs_c;
    logic              w_err_c;

    logic              bus_err_q;

    // Static AXI attributes: fixed IDs, 32-bit beats, INCR, normal access
    assign m_axi.arid    = ID_W'(RD_ID);
    assign m_axi.arsize  = 3'b010;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 2'b00;
    assign m_axi.arcache = 4'b0000;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.awid    = ID_W'(WR_ID);
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = 3'b010;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 2'b00;
    assign m_axi.awcache = 4'b0000;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wlast   = 1'b1;

    // Read channel outputs
    assign m_axi.araddr  = raddr_q;
    assign m_axi.arlen   = {4'b0000, rlen_q};
    assign m_axi.arvalid = (r_state == R_AR);
    assign m_axi.rready  = (r_state == R_DATA) & cache_rready_i;
    assign r_hs_c        = m_axi.rvalid & m_axi.rready;
    assign cache_rdata_o  = m_axi.rdata;
    assign cache_rvalid_o = r_hs_c;

    // Write channel outputs; W data comes from the latch once captured
    assign m_axi.awaddr  = waddr_q;
    assign m_axi.awvalid = (w_state == W_REQ) & ~aw_done_q;
    assign m_axi.wvalid  = (w_state == W_REQ) & cache_wvalid_i & ~w_done_q;
    assign m_axi.wdata   = wdata_vld_q ? wdata_q : cache_wdata_i;
    assign m_axi.bready  = (w_state == W_RESP);
    assign aw_hs_c       = m_axi.awvalid & m_axi.awready;
    assign w_hs_c        = m_axi.wvalid & m_axi.wready;
    assign b_hs_c        = m_axi.bvalid & m_axi.bready;
    assign cache_bvalid_o = b_hs_c;

    assign bus_err_o = bus_err_q;

    // Read engine state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            raddr_q <= '0;
            rlen_q  <= '0;
            beat_q  <= '0;
        end else begin
            r_state <= r_state_nxt;
            raddr_q <= raddr_nxt;
            rlen_q  <= rlen_nxt;
            beat_q  <= beat_nxt;
        end
    end

    // Read engine next state; beat count cross-checks rlast position
    always_comb begin
        r_state_nxt = r_state;
        raddr_nxt   = raddr_q;
        rlen_nxt    = rlen_q;
        beat_nxt    = beat_q;
        r_err_c     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (cache_ce_i && cache_ren_i) begin
                    raddr_nxt   = cache_raddr_i;
                    rlen_nxt    = cache_rlen_i;
                    beat_nxt    = '0;
                    r_state_nxt = R_AR;
                end
            end
            R_AR: begin
                if (m_axi.arready) begin
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs_c) begin
                    beat_nxt = beat_q + LEN_W'(1);
                    if (m_axi.rresp != 2'b00) begin
                        r_err_c = 1'b1;
                    end
                    if (m_axi.rlast != (beat_q == rlen_q)) begin
                        r_err_c = 1'b1;
                    end
                    if (m_axi.rlast) begin
                        r_state_nxt = R_IDLE;
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Write engine state register
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state     <= W_IDLE;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wdata_vld_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            w_state     <= w_state_nxt;
            waddr_q     <= waddr_nxt;
            wdata_q     <= wdata_nxt;
            wdata_vld_q <= wdata_vld_nxt;
            aw_done_q   <= aw_done_nxt;
            w_done_q    <= w_done_nxt;
        end
    end

    // Write engine next state; AW and W may complete in any order
    always_comb begin
        w_state_nxt   = w_state;
        waddr_nxt     = waddr_q;
        wdata_nxt     = wdata_q;
        wdata_vld_nxt = wdata_vld_q;
        aw_done_nxt   = aw_done_q;
        w_done_nxt    = w_done_q;
        w_err_c       = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (cache_ce_i && cache_wen_i) begin
                    waddr_nxt     = cache_waddr_i;
                    aw_done_nxt   = 1'b0;
                    w_done_nxt    = 1'b0;
                    // data presented together with the request is captured right away
                    wdata_vld_nxt = cache_wvalid_i;
                    if (cache_wvalid_i) begin
                        wdata_nxt = cache_wdata_i;
                    end
                    w_state_nxt   = W_REQ;
                end
            end
            W_REQ: begin
                if (cache_wvalid_i && !wdata_vld_q) begin
                    wdata_nxt     = cache_wdata_i;
                    wdata_vld_nxt = 1'b1;
                end
                if (aw_hs_c) begin
                    aw_done_nxt = 1'b1;
                end
                if (w_hs_c) begin
                    w_done_nxt = 1'b1;
                end
                if ((aw_done_q || aw_hs_c) && (w_done_q || w_hs_c)) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs_c) begin
                    w_err_c     = (m_axi.bresp != 2'b00);
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Sticky error, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_q | r_err_c | w_err_c;
        end
    end
endmodule

// File: tb/tb_axi_master_bridge.sv
// Randomized bench for axi_master_bridge: AXI slave responders, cache-side drivers,
// a negedge monitor, and expected data from a bench-owned memory function.
module tb_axi_master_bridge;
    localparam int TMO = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_ce_i;
    logic        cache_ren_i;
    logic        cache_rready_i;
    logic [31:0] cache_raddr_i;
    logic [3:0]  cache_rlen_i;
    logic [31:0] cache_rdata_o;
    logic        cache_rvalid_o;
    logic        cache_wen_i;
    logic [31:0] cache_waddr_i;
    logic [31:0] cache_wdata_i;
    logic        cache_wvalid_i;
    logic        cache_bvalid_o;
    logic        bus_err_o;

    axi_master_bridge_if #(.ID_W(4)) m_axi ();

    axi_master_bridge #(.ID_W(4), .RD_ID(0), .WR_ID(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .cache_ce_i     (cache_ce_i),
        .cache_ren_i    (cache_ren_i),
        .cache_rready_i (cache_rready_i),
        .cache_raddr_i  (cache_raddr_i),
        .cache_rlen_i   (cache_rlen_i),
        .cache_rdata_o  (cache_rdata_o),
        .cache_rvalid_o (cache_rvalid_o),
        .cache_wen_i    (cache_wen_i),
        .cache_waddr_i  (cache_waddr_i),
        .cache_wdata_i  (cache_wdata_i),
        .cache_wvalid_i (cache_wvalid_i),
        .cache_bvalid_o (cache_bvalid_o),
        .bus_err_o      (bus_err_o),
        .m_axi          (m_axi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit abort = 1'b0;

    int ar_hs = 0, aw_hs = 0, w_hs = 0, cb_pulses = 0, r_beats = 0;
    int ar0, aw0, w0, cb0;
    logic [31:0] rx_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
    logic [7:0]  seen_arlen, seen_awlen;
    logic [3:0]  seen_arid, seen_awid, seen_wstrb;
    logic [2:0]  seen_arsize, seen_awsize;
    logic [1:0]  seen_arburst, seen_awburst;
    logic        seen_wlast;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory image served by the slave
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1FC0_0004) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axi.arvalid && m_axi.arready) begin
                ar_hs        <= ar_hs + 1;
                seen_araddr  <= m_axi.araddr;
                seen_arlen   <= m_axi.arlen;
                seen_arid    <= m_axi.arid;
                seen_arsize  <= m_axi.arsize;
                seen_arburst <= m_axi.arburst;
            end
            if (m_axi.awvalid && m_axi.awready) begin
                aw_hs        <= aw_hs + 1;
                seen_awaddr  <= m_axi.awaddr;
                seen_awlen   <= m_axi.awlen;
                seen_awid    <= m_axi.awid;
                seen_awsize  <= m_axi.awsize;
                seen_awburst <= m_axi.awburst;
            end
            if (m_axi.wvalid && m_axi.wready) begin
                w_hs       <= w_hs + 1;
                seen_wdata <= m_axi.wdata;
                seen_wstrb <= m_axi.wstrb;
                seen_wlast <= m_axi.wlast;
            end
            if (cache_rvalid_o) begin
                r_beats <= r_beats + 1;
                rx_q.push_back(cache_rdata_o);
            end
            if (cache_bvalid_o) cb_pulses <= cb_pulses + 1;
        end
    end

    task automatic clear_inputs();
        cache_ce_i = 0; cache_ren_i = 0; cache_rready_i = 0; cache_raddr_i = 0; cache_rlen_i = 0;
        cache_wen_i = 0; cache_waddr_i = 0; cache_wdata_i = 0; cache_wvalid_i = 0;
        m_axi.arready = 0; m_axi.rvalid = 0; m_axi.rdata = 0; m_axi.rresp = 0; m_axi.rlast = 0;
        m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 0;
    endtask

    // AXI read slave; last_at < 0 means rlast on the final beat of arlen
    task automatic rd_slave(input int ar_lat, input int max_gap, input logic [1:0] resp, input int last_at);
        int lat, n, gap, last;
        logic v, h;
        logic [31:0] a;
        lat = ar_lat; n = 0; a = 0; last = last_at;
        forever begin
            @(negedge clk);
            v = m_axi.arvalid; h = v && m_axi.arready;
            a = m_axi.araddr;
            if (last_at < 0) last = int'(m_axi.arlen);
            if (h || abort) break;
            n++;
            if (n > TMO) begin check_eq("ar_timeout", 0, 1); abort = 1; break; end
            step();
            if (v) begin
                if (lat == 0) m_axi.arready = 1; else lat--;
            end
        end
        step();
        m_axi.arready = 0;
        for (int i = 0; i <= last && !abort; i++) begin
            gap = $urandom_range(0, max_gap);
            repeat (gap) step();
            m_axi.rvalid = 1; m_axi.rdata = mem_word(a + 32'(4 * i));
            m_axi.rresp = resp; m_axi.rlast = (i == last);
            n = 0;
            forever begin
                @(negedge clk);
                h = m_axi.rready;
                step();
                if (h || abort) break;
                n++;
                if (n > TMO) begin check_eq("r_timeout", 0, 1); abort = 1; break; end
            end
            m_axi.rvalid = 0; m_axi.rlast = 0;
        end
    endtask

    // Cache-side read: request, expected beats, first-request latency
    task automatic cache_read(input logic [31:0] a, input logic [3:0] len, input int n_exp);
        int beats, n;
        for (int i = 0; i < n_exp; i++) exp_q.push_back(mem_word(a + 32'(4 * i)));
        cache_ce_i = 1; cache_raddr_i = a; cache_rlen_i = len; cache_ren_i = 1;
        beats = 0; n = 0;
        while (beats < n_exp && !abort) begin
            @(negedge clk);
            if (n == 0) check_eq("rd_arvalid_c0", m_axi.arvalid, 0);
            if (n == 1) check_eq("rd_arvalid_c1", m_axi.arvalid, 1);
            if (cache_rvalid_o) beats++;
            n++;
            if (n > TMO) begin check_eq("rd_timeout", beats, n_exp); abort = 1; end
            step();
            cache_rready_i = ($urandom_range(0, 3) != 0);
        end
        cache_ren_i = 0; cache_rready_i = 0;
    endtask

    // AXI write slave: independent AW/W ready latencies, then B
    task automatic wr_slave(input int aw_lat, input int w_lat, input int b_gap, input logic [1:0] resp);
        int la, lw, na, nw, n;
        logic va, ha, vw, hw, h;
        la = aw_lat; lw = w_lat; na = 0; nw = 0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    va = m_axi.awvalid; ha = va && m_axi.awready;
                    step();
                    if (ha) m_axi.awready = 0;
                    if (ha || abort) break;
                    na++;
                    if (na > TMO) begin check_eq("aw_timeout", 0, 1); abort = 1; break; end
                    if (va) begin
                        if (la == 0) m_axi.awready = 1; else la--;
                    end
                end
            end
            begin
                forever begin
                    @(negedge clk);
                    vw = m_axi.wvalid; hw = vw && m_axi.wready;
                    step();
                    if (hw) m_axi.wready = 0;
                    if (hw || abort) break;
                    nw++;
                    if (nw > TMO) begin check_eq("w_timeout", 0, 1); abort = 1; break; end
                    if (vw) begin
                        if (lw == 0) m_axi.wready = 1; else lw--;
                    end
                end
            end
        join
        if (!abort) begin
            repeat (b_gap) step();
            m_axi.bvalid = 1; m_axi.bresp = resp;
            n = 0;
            forever begin
                @(negedge clk);
                h = m_axi.bready;
                step();
                if (h || abort) break;
                n++;
                if (n > TMO) begin check_eq("b_timeout", 0, 1); abort = 1; break; end
            end
            m_axi.bvalid = 0; m_axi.bresp = 0;
        end
    endtask

    // Cache-side write; upstream data changes after its first valid cycle
    task automatic cache_write(input logic [31:0] a, input logic [31:0] d, input int wv_delay);
        int n;
        logic h;
        cache_ce_i = 1; cache_waddr_i = a; cache_wen_i = 1; cache_wvalid_i = 0;
        repeat (wv_delay) step();
        cache_wvalid_i = 1; cache_wdata_i = d;
        step();
        cache_wdata_i = ~d;
        n = 0;
        forever begin
            @(negedge clk);
            h = cache_bvalid_o;
            step();
            if (h || abort) break;
            n++;
            if (n > TMO) begin check_eq("bvalid_timeout", 0, 1); abort = 1; break; end
        end
        cache_wen_i = 0; cache_wvalid_i = 0;
    endtask

    task automatic snap();
        ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs; cb0 = cb_pulses;
    endtask

    task automatic check_reads(input string tag, input logic [31:0] a, input logic [7:0] len);
        check_eq({tag, "_araddr"}, seen_araddr, a);
        check_eq({tag, "_arlen"}, seen_arlen, len);
        check_eq({tag, "_arid"}, seen_arid, 0);
        check_eq({tag, "_arsize"}, seen_arsize, 3'b010);
        check_eq({tag, "_arburst"}, seen_arburst, 2'b01);
        check_eq({tag, "_ar_count"}, ar_hs - ar0, 1);
        check_eq({tag, "_nbeats"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check_eq({tag, "_beat"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        check_eq({tag, "_awaddr"}, seen_awaddr, a);
        check_eq({tag, "_awid"}, seen_awid, 1);
        check_eq({tag, "_awlen"}, seen_awlen, 0);
        check_eq({tag, "_awsize"}, seen_awsize, 3'b010);
        check_eq({tag, "_awburst"}, seen_awburst, 2'b01);
        check_eq({tag, "_wdata"}, seen_wdata, d);
        check_eq({tag, "_wstrb"}, seen_wstrb, 4'hF);
        check_eq({tag, "_wlast"}, seen_wlast, 1);
        check_eq({tag, "_aw_count"}, aw_hs - aw0, 1);
        check_eq({tag, "_w_count"}, w_hs - w0, 1);
        check_eq({tag, "_bvalid_pulses"}, cb_pulses - cb0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, wa, wd;
        logic [3:0]  rl;
        int n, rb0;

        clear_inputs();
        rst = 1;
        repeat (3) step();
        rst = 0;
        @(negedge clk);
        check_eq("rst_arvalid", m_axi.arvalid, 0);
        check_eq("rst_rready", m_axi.rready, 0);
        check_eq("rst_awvalid", m_axi.awvalid, 0);
        check_eq("rst_wvalid", m_axi.wvalid, 0);
        check_eq("rst_bready", m_axi.bready, 0);
        check_eq("rst_bus_err", bus_err_o, 0);
        check_eq("rst_araddr", m_axi.araddr, 0);
        check_eq("rst_arlen", m_axi.arlen, 0);
        step();

        // single-word read
        snap();
        fork
            cache_read(32'h1FC0_0004, 4'd0, 1);
            rd_slave(0, 0, 2'b00, -1);
        join
        check_reads("t1", 32'h1FC0_0004, 8'd0);

        // 8-beat line with gaps, then an immediate back-to-back request
        snap();
        fork
            cache_read(32'h0000_0100, 4'd7, 8);
            rd_slave(1, 3, 2'b00, -1);
        join
        check_reads("t2", 32'h0000_0100, 8'd7);
        snap();
        fork
            cache_read(32'h0000_0200, 4'd0, 1);
            rd_slave(0, 2, 2'b00, -1);
        join
        check_reads("t2b", 32'h0000_0200, 8'd0);

        // W before AW, then AW and W in the same cycle
        snap();
        fork
            cache_write(32'h8000_0010, 32'h1234_5678, 0);
            wr_slave(3, 0, 0, 2'b00);
        join
        check_write("t3a", 32'h8000_0010, 32'h1234_5678);
        snap();
        fork
            cache_write(32'h8000_0010, 32'h1234_5678, 0);
            wr_slave(1, 1, 1, 2'b00);
        join
        check_write("t3b", 32'h8000_0010, 32'h1234_5678);

        // concurrent read and write with random stalls
        for (int k = 0; k < 5; k++) begin
            ra = $urandom & 32'hFFFF_FFFC;
            wa = $urandom & 32'hFFFF_FFFC;
            wd = $urandom;
            rl = (k == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            snap();
            fork
                cache_read(ra, rl, int'(rl) + 1);
                rd_slave($urandom_range(0, 3), 3, 2'b00, -1);
                cache_write(wa, wd, $urandom_range(0, 4));
                wr_slave($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 2'b00);
            join
            check_reads("t4_rd", ra, {4'b0000, rl});
            check_write("t4_wr", wa, wd);
        end
        check_eq("t4_bus_err", bus_err_o, 0);

        // SLVERR on write makes the error sticky across a clean read
        snap();
        fork
            cache_write(32'h8000_0020, 32'hCAFE_F00D, 0);
            wr_slave(0, 0, 1, 2'b10);
        join
        check_write("t5_wr", 32'h8000_0020, 32'hCAFE_F00D);
        check_eq("t5_bus_err_set", bus_err_o, 1);
        snap();
        fork
            cache_read(32'h0000_0300, 4'd3, 4);
            rd_slave(0, 1, 2'b00, -1);
        join
        check_reads("t5_rd", 32'h0000_0300, 8'd3);
        check_eq("t5_bus_err_sticky", bus_err_o, 1);

        // reset during beat 4 of 8 with a write in flight
        rb0 = r_beats;
        fork
            cache_read(32'h0000_2000, 4'd7, 8);
            rd_slave(0, 1, 2'b00, -1);
            cache_write(32'h3000_0000, 32'h0BAD_0BAD, 0);
            wr_slave(30, 30, 0, 2'b00);
            begin
                n = 0;
                while (r_beats - rb0 < 3 && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                check_eq("t6_beats_before_rst", (r_beats - rb0 >= 3), 1);
                step();
                rst = 1;
                abort = 1;
            end
        join
        clear_inputs();
        cache_ren_i = 1; cache_wen_i = 1; cache_rready_i = 1; cache_wvalid_i = 1;
        step();
        rst = 0;
        @(negedge clk);
        check_eq("t6_arvalid", m_axi.arvalid, 0);
        check_eq("t6_rready", m_axi.rready, 0);
        check_eq("t6_awvalid", m_axi.awvalid, 0);
        check_eq("t6_wvalid", m_axi.wvalid, 0);
        check_eq("t6_bready", m_axi.bready, 0);
        check_eq("t6_rvalid_o", cache_rvalid_o, 0);
        check_eq("t6_bus_err_clr", bus_err_o, 0);
        check_eq("t6_araddr_clr", m_axi.araddr, 0);
        step();
        @(negedge clk);
        check_eq("t6_ce_blocks_ar", m_axi.arvalid, 0);
        check_eq("t6_ce_blocks_aw", m_axi.awvalid, 0);
        step();
        clear_inputs();
        abort = 0;
        rx_q.delete();
        exp_q.delete();
        snap();
        fork
            cache_read(32'h0000_0040, 4'd0, 1);
            rd_slave(0, 1, 2'b00, -1);
        join
        check_reads("t6_rd", 32'h0000_0040, 8'd0);
        check_eq("t6_bus_err_after", bus_err_o, 0);

        // early rlast on a 4-beat request: error, engine still exits
        snap();
        fork
            cache_read(32'h0000_0080, 4'd3, 2);
            rd_slave(0, 1, 2'b00, 1);
        join
        check_reads("t7", 32'h0000_0080, 8'd3);
        check_eq("t7_bus_err", bus_err_o, 1);
        snap();
        fork
            cache_read(32'h0000_00C0, 4'd1, 2);
            rd_slave(0, 1, 2'b00, -1);
        join
        check_reads("t7_next", 32'h0000_00C0, 8'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
